// File: rtl/cdc_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_arb_pkg
//  Description : Shared types and constants for the cdc_tx_arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : cdc_arb_pkg
`default_nettype wire

// File: rtl/cdc_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_tx_arbiter_if
//  Description : Requester-side bus and transmit-lane outputs of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_tx_arbiter_if
    import cdc_arb_pkg::*;
#(
    parameter int NREQ = 4
) ();

    logic                       enable;
    logic [NREQ-1:0]            req;
    logic [NREQ*BYTE_W-1:0]     data;
    logic [NREQ-1:0]            ack;
    logic                       trigger;
    logic [BYTE_W-1:0]          data_out;
    logic [clog2(NREQ)-1:0]     grant_id;
    logic                       busy;

    modport master (
        output enable, req, data,
        input  ack, trigger, data_out, grant_id, busy
    );

    modport slave (
        input  enable, req, data,
        output ack, trigger, data_out, grant_id, busy
    );

endinterface : cdc_tx_arbiter_if
`default_nettype wire

// File: rtl/cdc_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_arb_rr_pick
//  Description : Combinational round-robin picker searching upward from ptr.
//                CDC_ARB_PRIO0_EN makes requester 0 strict-priority and
//                rotates only over 1..NREQ-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_arb_rr_pick
    import cdc_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [PW-1:0]   ptr,
    input  wire logic            enable,
    output logic      [PW-1:0]   winner,
    output logic                 valid
);

    int idx;
`ifdef CDC_ARB_PRIO0_EN
    int base;
`endif

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
`ifdef CDC_ARB_PRIO0_EN
        // A pointer of 0 (reset value) is treated as the start of the 1.. range.
        base = (ptr == '0) ? 1 : int'(ptr);
        if (req[0]) begin
            valid = 1'b1;
        end
        for (int k = 0; k < NREQ - 1; k++) begin
            idx = 1 + ((base - 1 + k) % (NREQ - 1));
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
`endif
        if (!enable) begin
            valid  = 1'b0;
            winner = '0;
        end
    end

endmodule : cdc_arb_rr_pick
`default_nettype wire

// File: rtl/cdc_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_tx_arbiter
//  Description : Shares one byte-wide trigger/data lane among NREQ requesters,
//                emitting a one-cycle pulse followed by a zero-framed gap.
//                Optional macro: CDC_ARB_PRIO0_EN (requester 0 strict priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 3
) (
    input  wire logic        clk_100,
    input  wire logic        reset_n,
    cdc_tx_arbiter_if.slave  bus
);

    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(GAP_CYCLES + 1);

    state_t              state_q,    state_d;
    logic [PW-1:0]       ptr_q,      ptr_d;
    logic [CW-1:0]       cnt_q,      cnt_d;
    logic                trigger_q,  trigger_d;
    logic [BYTE_W-1:0]   data_out_q, data_out_d;
    logic [NREQ-1:0]     ack_q,      ack_d;
    logic [PW-1:0]       grant_id_q, grant_id_d;
    logic                busy_q,     busy_d;

    logic [PW-1:0]       pick_idx;
    logic                pick_valid;
    logic [PW-1:0]       ptr_next;

    cdc_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .enable (bus.enable),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
`ifdef CDC_ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation untouched.
        if (pick_idx == '0) begin
            ptr_next = ptr_q;
        end else if (pick_idx == PW'(NREQ - 1)) begin
            ptr_next = PW'(1);
        end else begin
            ptr_next = pick_idx + PW'(1);
        end
`else
        ptr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
`endif
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        trigger_d  = 1'b0;
        data_out_d = '0;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (pick_valid) begin
                    state_d           = ST_ISSUE;
                    trigger_d         = 1'b1;
                    data_out_d        = bus.data[int'(pick_idx)*BYTE_W +: BYTE_W];
                    ack_d[pick_idx]   = 1'b1;
                    grant_id_d        = pick_idx;
                    busy_d            = 1'b1;
                    ptr_d             = ptr_next;
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLDOFF;
                cnt_d   = CW'(GAP_CYCLES - 1);
                busy_d  = 1'b1;
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q - CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            trigger_q  <= 1'b0;
            data_out_q <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            trigger_q  <= trigger_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.trigger  = trigger_q;
    assign bus.data_out = data_out_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

endmodule : cdc_tx_arbiter
`default_nettype wire

// File: tb/tb_cdc_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_tx_arbiter
//  Description : Directed self-checking bench for cdc_tx_arbiter (NREQ=4, GAP=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_tx_arbiter;

    logic clk_100 = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    cdc_tx_arbiter_if #(.NREQ(4)) bus ();

    cdc_tx_arbiter #(
        .NREQ       (4),
        .GAP_CYCLES (3)
    ) dut (
        .clk_100 (clk_100),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.req    = '0;
        bus.enable = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_trig(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 20) begin
            tick();
            cyc = cyc + 1;
            ok  = (bus.trigger === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.req    = '0;
        bus.enable = 1'b1;
        bus.data   = 32'h44A52211;
        repeat (2) tick();
        checks++;
        if ({bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%b ack=%b data=%h gid=%0d busy=%b, required all 0",
                     bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: trig=%b busy=%b, required 0 0", bus.trigger, bus.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        tick();
        checks++;
        if ({bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy} !==
            {1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL single_issue: trig=%b ack=%b data=%h gid=%0d busy=%b, required 1 0100 a5 2 1",
                     bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy);
        end
        bus.req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.trigger, bus.ack, bus.data_out, bus.busy} !== {1'b0, 4'b0, 8'h00, 1'b1}) begin
                errors++;
                $display("FAIL single_gap%0d: trig=%b ack=%b data=%h busy=%b, required 0 0000 00 1",
                         i, bus.trigger, bus.ack, bus.data_out, bus.busy);
            end
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_end: busy=%b gid=%0d, required 0 2", bus.busy, bus.grant_id);
        end
    endtask

    task automatic test_round_robin();
        int  cyc;
        bit  ok;
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11};
        logic [3:0] exp_a;
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_trig(cyc, ok);
            exp_a = 4'b0001 << exp_g[n];
            checks++;
            if (!ok || bus.grant_id !== exp_g[n] || bus.ack !== exp_a || bus.data_out !== exp_d[n]) begin
                errors++;
                $display("FAIL rr_grant%0d: seen=%b gid=%0d ack=%b data=%h, required gid=%0d ack=%b data=%h",
                         n, ok, bus.grant_id, bus.ack, bus.data_out, exp_g[n], exp_a, exp_d[n]);
            end
            checks++;
            if (cyc != ((n == 0) ? 1 : 5)) begin
                errors++;
                $display("FAIL rr_spacing%0d: cycles=%0d, required %0d", n, cyc, (n == 0) ? 1 : 5);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        logic [1:0] exp_g [3] = '{2'd3, 2'd0, 2'd3};
        do_reset();
        bus.req = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            wait_trig(cyc, ok);
            if (n == 0) bus.req = 4'b1001;
            checks++;
            if (!ok || bus.grant_id !== exp_g[n]) begin
                errors++;
                $display("FAIL wrap_grant%0d: seen=%b gid=%0d, required %0d", n, ok, bus.grant_id, exp_g[n]);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_enable();
        int ntrig;
        do_reset();
        bus.enable = 1'b0;
        bus.req    = 4'b0011;
        ntrig      = 0;
        repeat (8) begin
            tick();
            if (bus.trigger === 1'b1) ntrig++;
        end
        checks++;
        if (ntrig != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: triggers=%0d busy=%b, required 0 0", ntrig, bus.busy);
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.trigger !== 1'b1 || bus.grant_id !== 2'd0 || bus.ack !== 4'b0001) begin
            errors++;
            $display("FAIL enable_on: trig=%b gid=%0d ack=%b, required 1 0 0001",
                     bus.trigger, bus.grant_id, bus.ack);
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid_issue();
        int cyc;
        bit ok;
        do_reset();
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.trigger !== 1'b1 || bus.grant_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_pre: trig=%b gid=%0d, required 1 2", bus.trigger, bus.grant_id);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: trig=%b ack=%b data=%h gid=%0d busy=%b, required all 0",
                     bus.trigger, bus.ack, bus.data_out, bus.grant_id, bus.busy);
        end
        bus.req = '0;
        tick();
        reset_n = 1'b1;
        // Requesters 1 and 3 both pending: a cleared pointer makes 1 the winner.
        bus.req = 4'b1010;
        wait_trig(cyc, ok);
        checks++;
        if (!ok || cyc != 1 || bus.grant_id !== 2'd1 || bus.data_out !== 8'h22) begin
            errors++;
            $display("FAIL mid_after: seen=%b cycles=%0d gid=%0d data=%h, required 1 1 1 22",
                     ok, cyc, bus.grant_id, bus.data_out);
        end
        bus.req = '0;
    endtask

`ifdef CDC_ARB_PRIO0_EN
    task automatic test_prio0();
        int cyc;
        bit ok;
        logic [1:0] exp_g [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 7; n++) begin
            wait_trig(cyc, ok);
            if (n == 2) bus.req = 4'b1110;
            checks++;
            if (!ok || bus.grant_id !== exp_g[n]) begin
                errors++;
                $display("FAIL prio_grant%0d: seen=%b gid=%0d, required %0d", n, ok, bus.grant_id, exp_g[n]);
            end
        end
        bus.req = '0;
    endtask
`endif

    initial begin
        bus.enable = 1'b1;
        bus.req    = '0;
        bus.data   = 32'h44A52211;
        test_reset();
        test_single();
`ifdef CDC_ARB_PRIO0_EN
        test_prio0();
`else
        test_round_robin();
        test_wrap();
`endif
        test_enable();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cdc_tx_arbiter
`default_nettype wire
